// File: rtl/image_ram_arbiter.sv
// -----------------------------------------------------------------------------
// image_ram_arbiter
//
// Shares the single port (port A) of the sprite image BRAM between the display
// fetch path and a bulk image loader. Display reads always win and pass through
// a purely combinational mux, so they see no added latency. The loader streams
// bytes over a valid/ready handshake and writes them to sequential addresses,
// but only in cycles that the display does not claim.
//
// Ports:
//   pixel_clk_in     pixel clock (only clock in the block)
//   rst_in           asynchronous, active-high reset
//   rd_req_in        display claims the RAM port this cycle
//   rd_addr_in       display read address
//   load_start_in    pulse: begin a full-image load (honoured only when idle)
//   load_abort_in    pulse: cancel an in-progress load
//   wr_data_in       loader byte
//   wr_valid_in      loader byte valid
//   wr_ready_out     arbiter accepts wr_data_in this cycle
//   ram_addr_out     RAM addra
//   ram_din_out      RAM dina
//   ram_we_out       RAM wea
//   load_busy_out    high while a load is in progress
//   load_done_out    one-cycle pulse after the last byte has been written
//   wr_ptr_out       next loader write address
//   stall_count_out  cycles a valid loader byte was blocked by a display read
// -----------------------------------------------------------------------------
module image_ram_arbiter #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              rd_req_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              load_start_in,
  input  logic              load_abort_in,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              wr_valid_in,
  output logic              wr_ready_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_din_out,
  output logic              ram_we_out,
  output logic              load_busy_out,
  output logic              load_done_out,
  output logic [ADDR_W-1:0] wr_ptr_out,
  output logic [15:0]       stall_count_out
);

  localparam int                DEPTH     = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] w_wr_ptr_next;
  logic [15:0]       r_stall_count;
  logic [15:0]       w_stall_count_next;

  logic w_accept;
  logic w_write;
  logic w_stalled;

  // Handshake: the loader may only proceed while loading and the display is
  // not using the port.
  assign wr_ready_out = (r_state == LOAD) && !rd_req_in;
  assign w_accept     = wr_valid_in && wr_ready_out;
  // An abort in the same cycle as an accept wins: that byte is dropped.
  assign w_write      = w_accept && !load_abort_in;
  assign w_stalled    = (r_state == LOAD) && wr_valid_in && rd_req_in;

  // Port mux. w_write is already false whenever rd_req_in is high, so the
  // display address is the default and the write path overrides it.
  always_comb begin
    ram_addr_out = rd_addr_in;
    ram_din_out  = '0;
    ram_we_out   = 1'b0;
    if (w_write) begin
      ram_addr_out = r_wr_ptr;
      ram_din_out  = wr_data_in;
      ram_we_out   = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next       = r_state;
    w_wr_ptr_next      = r_wr_ptr;
    w_stall_count_next = r_stall_count;

    unique case (r_state)
      IDLE: begin
        if (load_start_in) begin
          w_state_next       = LOAD;
          w_wr_ptr_next      = '0;
          w_stall_count_next = '0;
        end
      end

      LOAD: begin
        if (w_stalled && (r_stall_count != 16'hFFFF)) begin
          w_stall_count_next = r_stall_count + 16'd1;
        end
        if (load_abort_in) begin
          w_state_next  = IDLE;
          w_wr_ptr_next = '0;
        end else if (w_write) begin
          if (r_wr_ptr == LAST_ADDR) begin
            // Explicit wrap so non-power-of-two images never run past the end.
            w_state_next  = DONE;
            w_wr_ptr_next = '0;
          end else begin
            w_wr_ptr_next = r_wr_ptr + 1'b1;
          end
        end
      end

      DONE: begin
        // Single-cycle completion state; start/abort are ignored here.
        w_state_next = IDLE;
      end

      default: begin
        w_state_next  = IDLE;
        w_wr_ptr_next = '0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_stall_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_wr_ptr      <= w_wr_ptr_next;
      r_stall_count <= w_stall_count_next;
    end
  end

  // Moore status outputs
  assign load_busy_out   = (r_state == LOAD);
  assign load_done_out   = (r_state == DONE);
  assign wr_ptr_out      = r_wr_ptr;
  assign stall_count_out = r_stall_count;

endmodule

// File: tb/tb_image_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_image_ram_arbiter
//
// Randomized, self-checking bench for image_ram_arbiter with a reduced image
// size (64x32) so full loads stay short. A cycle-level reference model built
// from the behavioural rules (loading flag, next address, stall count, pending
// done pulse, expected image contents) predicts every output; a simulated RAM
// driven from the DUT's port is compared with the expected image afterwards.
// -----------------------------------------------------------------------------
module tb_image_ram_arbiter;

  localparam int W     = 64;
  localparam int H     = 32;
  localparam int DEPTH = W * H;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = 8;

  logic          pixel_clk_in;
  logic          rst_in;
  logic          rd_req_in;
  logic [AW-1:0] rd_addr_in;
  logic          load_start_in;
  logic          load_abort_in;
  logic [DW-1:0] wr_data_in;
  logic          wr_valid_in;
  logic          wr_ready_out;
  logic [AW-1:0] ram_addr_out;
  logic [DW-1:0] ram_din_out;
  logic          ram_we_out;
  logic          load_busy_out;
  logic          load_done_out;
  logic [AW-1:0] wr_ptr_out;
  logic [15:0]   stall_count_out;

  image_ram_arbiter #(
    .WIDTH (W),
    .HEIGHT(H),
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .pixel_clk_in   (pixel_clk_in),
    .rst_in         (rst_in),
    .rd_req_in      (rd_req_in),
    .rd_addr_in     (rd_addr_in),
    .load_start_in  (load_start_in),
    .load_abort_in  (load_abort_in),
    .wr_data_in     (wr_data_in),
    .wr_valid_in    (wr_valid_in),
    .wr_ready_out   (wr_ready_out),
    .ram_addr_out   (ram_addr_out),
    .ram_din_out    (ram_din_out),
    .ram_we_out     (ram_we_out),
    .load_busy_out  (load_busy_out),
    .load_done_out  (load_done_out),
    .wr_ptr_out     (wr_ptr_out),
    .stall_count_out(stall_count_out)
  );

  initial pixel_clk_in = 1'b0;
  always #5 pixel_clk_in = ~pixel_clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_loading;
  bit m_done;
  int m_next;
  int m_stall;
  logic [DW-1:0] exp_img [DEPTH];

  // RAM as seen through the DUT's port
  logic [DW-1:0] ram_sim [DEPTH];
  int            wr_cnt  [DEPTH];
  int            done_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0;
    m_done    = 1'b0;
    m_next    = 0;
    m_stall   = 0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < DEPTH; i++) wr_cnt[i] = 0;
    done_seen = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check every output
  // against the model, then advance the model across the rising edge.
  task automatic step(input logic rd, input logic [AW-1:0] ra, input logic st,
                      input logic ab, input logic [DW-1:0] d, input logic v);
    logic          exp_ready;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_din;
    @(negedge pixel_clk_in);
    rd_req_in     = rd;
    rd_addr_in    = ra;
    load_start_in = st;
    load_abort_in = ab;
    wr_data_in    = d;
    wr_valid_in   = v;
    #1;
    exp_ready = m_loading && !rd;
    exp_we    = exp_ready && v && !ab;
    exp_addr  = exp_we ? AW'(m_next) : ra;
    exp_din   = exp_we ? d : '0;
    chk("wr_ready", 32'(wr_ready_out), 32'(exp_ready));
    chk("ram_we", 32'(ram_we_out), 32'(exp_we));
    chk("ram_addr", 32'(ram_addr_out), 32'(exp_addr));
    chk("ram_din", 32'(ram_din_out), 32'(exp_din));
    chk("load_busy", 32'(load_busy_out), 32'(m_loading));
    chk("load_done", 32'(load_done_out), 32'(m_done));
    chk("wr_ptr", 32'(wr_ptr_out), 32'(m_next));
    chk("stall_count", 32'(stall_count_out), 32'(m_stall));
    chk("we_during_rd", 32'(ram_we_out && rd_req_in), 32'd0);
    if (load_done_out === 1'b1) done_seen++;
    cap_we   = ram_we_out;
    cap_addr = ram_addr_out;
    cap_din  = ram_din_out;
    @(posedge pixel_clk_in);
    if (cap_we === 1'b1) begin
      ram_sim[cap_addr] = cap_din;
      wr_cnt[cap_addr]++;
    end
    // Model update
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_loading) begin
      if (st) begin
        m_loading = 1'b1;
        m_next    = 0;
        m_stall   = 0;
      end
    end else begin
      if (v && rd && m_stall < 65535) m_stall++;
      if (ab) begin
        m_loading = 1'b0;
        m_next    = 0;
      end else if (exp_we) begin
        exp_img[m_next] = d;
        if (m_next == DEPTH - 1) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
          m_next    = 0;
        end else begin
          m_next++;
        end
      end
    end
  endtask

  task automatic idle_step();
    step(1'b0, AW'($urandom), 1'b0, 1'b0, DW'($urandom), 1'b0);
  endtask

  task automatic check_image(input string tag);
    int bad_data;
    int bad_cnt;
    bad_data = 0;
    bad_cnt  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ram_sim[i] !== exp_img[i]) bad_data++;
      if (wr_cnt[i] != 1) bad_cnt++;
    end
    chk({tag, "_data_mismatches"}, 32'(bad_data), 32'd0);
    chk({tag, "_write_count_errors"}, 32'(bad_cnt), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_seen), 32'd1);
  endtask

  initial begin
    int cyc;
    rst_in        = 1'b1;
    rd_req_in     = 1'b0;
    rd_addr_in    = '0;
    load_start_in = 1'b0;
    load_abort_in = 1'b0;
    wr_data_in    = '0;
    wr_valid_in   = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      exp_img[i] = '0;
      ram_sim[i] = '0;
    end
    clear_counts();

    // Reset state
    #2;
    chk("rst_busy", 32'(load_busy_out), 32'd0);
    chk("rst_done", 32'(load_done_out), 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr_out), 32'd0);
    chk("rst_stall", 32'(stall_count_out), 32'd0);
    @(negedge pixel_clk_in);
    rst_in = 1'b0;

    // Idle display reads pass straight through
    step(1'b1, AW'(11'h234), 1'b0, 1'b0, 8'hA5, 1'b1);
    step(1'b1, AW'(11'h5C3), 1'b0, 1'b0, 8'h3C, 1'b0);
    idle_step();
    $display("idle read passthrough done, checks=%0d errors=%0d", n_checks, n_errors);

    // Full load, no contention, data = low address byte
    clear_counts();
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, AW'($urandom), 1'b0, 1'b0, DW'(i), 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);  // DONE pulse cycle
    idle_step();
    check_image("full_load");
    $display("full load complete, checks=%0d errors=%0d", n_checks, n_errors);

    // Contention: display claims every other cycle
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 100; i++)
      step((i % 2) == 0, AW'($urandom), 1'b0, 1'b0, DW'($urandom), 1'b1);
    #2;
    chk("contention_wr_ptr", 32'(wr_ptr_out), 32'd50);
    chk("contention_stall", 32'(stall_count_out), 32'd50);
    step(1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
    idle_step();
    $display("contention load aborted, checks=%0d errors=%0d", n_checks, n_errors);

    // Random backpressure, gaps and ignored restart requests for a full load
    clear_counts();
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cyc = 0;
    while (m_loading && cyc < 20 * DEPTH) begin
      step($urandom_range(0, 9) < 3, AW'($urandom), $urandom_range(0, 49) == 0,
           1'b0, DW'($urandom), $urandom_range(0, 9) < 7);
      cyc++;
    end
    if (m_loading) chk("random_load_timeout", 32'd1, 32'd0);
    step(1'b0, '0, 1'b1, 1'b1, '0, 1'b1);  // DONE cycle: start/abort ignored
    idle_step();
    check_image("random_load");
    $display("random load complete in %0d cycles, checks=%0d errors=%0d", cyc, n_checks, n_errors);

    // Abort coinciding with a valid accept at address 300
    done_seen = 0;
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, '0, 1'b0, 1'b0, DW'($urandom), 1'b1);
    chk("abort_ptr_before", 32'(m_next), 32'd300);
    step(1'b0, AW'(7), 1'b0, 1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 3; i++) idle_step();
    chk("abort_no_done", 32'(done_seen), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, AW'(9), 1'b0, 1'b0, 8'hC3, 1'b1);
    step(1'b0, AW'(9), 1'b0, 1'b0, 8'h3C, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
    $display("abort at 300 and restart done, checks=%0d errors=%0d", n_checks, n_errors);

    // Asynchronous reset in the middle of a load (with some stalls)
    done_seen = 0;
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    cyc = 0;
    while (m_next < 1000 && cyc < 4 * DEPTH) begin
      step((cyc % 7) == 0, AW'($urandom), 1'b0, 1'b0, DW'($urandom), 1'b1);
      cyc++;
    end
    chk("pre_reset_ptr", 32'(m_next), 32'd1000);
    #3;
    rst_in = 1'b1;
    #1;
    chk("async_rst_busy", 32'(load_busy_out), 32'd0);
    chk("async_rst_wr_ptr", 32'(wr_ptr_out), 32'd0);
    chk("async_rst_stall", 32'(stall_count_out), 32'd0);
    chk("async_rst_done", 32'(load_done_out), 32'd0);
    chk("async_rst_we", 32'(ram_we_out), 32'd0);
    chk("async_rst_ready", 32'(wr_ready_out), 32'd0);
    model_reset();
    @(negedge pixel_clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, DW'($urandom), 1'b1);
    chk("post_reset_no_done", 32'(done_seen), 32'd0);
    $display("async reset mid-load done, checks=%0d errors=%0d", n_checks, n_errors);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/image_ram_arbiter.md
Name: image_ram_arbiter

Overview:
Shares the single port of the sprite image BRAM (8-bit palette indices, WIDTH*HEIGHT entries) between the display fetch path and a bulk image loader. Display reads have absolute priority and pass through with zero added latency. The loader streams bytes in over a valid/ready handshake and writes them to sequential addresses only in cycles the display does not claim. It sits between the sprite renderer, the upstream byte source (UART/camera), and the image RAM's port A.

Parameters:
WIDTH, 256, sprite width in pixels
HEIGHT, 256, sprite height in pixels
DATA_W, 8, image RAM data width (palette index)
ADDR_W, $clog2(WIDTH*HEIGHT) = 16, image RAM address width

Ports:
pixel_clk_in  input  1  pixel clock; only clock in the block
rst_in  input  1  reset, asynchronous, active-high
rd_req_in  input  1  display claims the RAM port this cycle
rd_addr_in  input  ADDR_W  display read address
load_start_in  input  1  one-cycle pulse; begin a full-image load
load_abort_in  input  1  one-cycle pulse; cancel an in-progress load
wr_data_in  input  DATA_W  loader byte
wr_valid_in  input  1  loader byte valid
wr_ready_out  output  1  arbiter accepts wr_data_in this cycle
ram_addr_out  output  ADDR_W  to RAM addra
ram_din_out  output  DATA_W  to RAM dina
ram_we_out  output  1  to RAM wea
load_busy_out  output  1  high while state is LOAD
load_done_out  output  1  one-cycle pulse when the last byte is written
wr_ptr_out  output  ADDR_W  next write address
stall_count_out  output  16  cycles a valid loader byte was blocked by a display read

Behaviour:
- States: IDLE, LOAD, DONE. Reset (async) forces IDLE with wr_ptr=0, stall_count=0, load_done_out=0, load_busy_out=0.
- Port mux is combinational, so display latency is unchanged:
  - rd_req_in=1: ram_addr_out=rd_addr_in, ram_we_out=0, ram_din_out=0.
  - Otherwise, if a write is accepted: ram_addr_out=wr_ptr, ram_din_out=wr_data_in, ram_we_out=1.
  - Otherwise: ram_addr_out=rd_addr_in, ram_we_out=0, ram_din_out=0.
- wr_ready_out = (state==LOAD) && !rd_req_in (combinational). Accept = wr_valid_in && wr_ready_out.
- ram_we_out is never 1 outside LOAD and never 1 while rd_req_in=1.
- IDLE: load_start_in -> LOAD, wr_ptr<=0.
- LOAD:
  - On accept, wr_ptr<=wr_ptr+1.
  - If the accept is at wr_ptr==WIDTH*HEIGHT-1: go to DONE, and wr_ptr wraps to 0 (no overflow past the last address).
  - load_abort_in -> IDLE, wr_ptr<=0, no done pulse. Abort has priority over a same-cycle accept: that byte is not written, so ram_we_out=0 when load_abort_in=1.
  - load_start_in is ignored while in LOAD (no restart).
- DONE: lasts exactly one cycle with load_done_out=1, then IDLE. load_start_in or load_abort_in during DONE is ignored.
- load_done_out and load_busy_out are decoded from registered state (Moore outputs).
- stall_count increments when state==LOAD && wr_valid_in && rd_req_in. It saturates at 16'hFFFF, and clears to 0 on load_start_in accepted in IDLE.
- Reset mid-load: the load is abandoned, the RAM keeps its partial contents, and no done pulse is produced.
- No X on outputs after reset; wr_data_in is ignored when not accepted.

Test Plan:
- Reset then idle: rst_in pulse, rd_req_in=1, rd_addr_in=16'h1234 -> ram_addr_out=16'h1234, ram_we_out=0, wr_ready_out=0, load_busy_out=0.
- Full load, no contention: load_start_in, wr_valid_in=1 for 65536 cycles with data=addr[7:0] -> 65536 writes at addresses 0..65535, ram_din_out=addr[7:0]. load_done_out pulses exactly once, one cycle after the last accept, then IDLE with wr_ptr_out=0. Memory model matches.
- Contention: during LOAD, rd_req_in high on alternate cycles with wr_valid_in=1 -> writes only on rd_req_in=0 cycles, ram_addr_out=rd_addr_in on read cycles, and stall_count_out increments by 1 per blocked cycle. After 100 cycles, 50 bytes are written and stall_count_out=50.
- Backpressure/gaps: random wr_valid_in and rd_req_in for a full load -> each byte is written exactly once, in order, with no address skipped or duplicated. ram_we_out && rd_req_in is never true.
- Abort: abort at wr_ptr=300 in the same cycle as a valid accept -> byte not written, IDLE, wr_ptr_out=0, no load_done_out. A subsequent load_start_in restarts at address 0.
- Async reset mid-load: assert rst_in between clock edges at wr_ptr=1000 -> outputs go to reset values immediately, with no done pulse after deassert.
